updown_limit_counter: RTL and testbench

Parametrised up/down counter, successor to the team's fixed 4-bit preload/enable counter. Adds a configurable data width, a runtime-programmable upper limit, direction control, wrap/saturate selection, and a one-cycle wrap pulse alongside the terminal-detect flag. It is used as a reusable event/timeout counter in block-level testbench DUTs and small control datapaths.

---
 rtl/updown_limit_counter.sv | 71 +++++++
 tb/tb_updown_limit_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/updown_limit_counter.sv
// Parametrised up/down event counter with a runtime upper limit.
// Supports wrap/saturate selection, clamped preload, a terminal flag and a wrap pulse.
module updown_limit_counter #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             wrap_en,
    input  logic             preload,
    input  logic [WIDTH-1:0] preload_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             term_hit,
    output logic             wrap_pulse
);

    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] terminal;
    logic             next_term;
    logic             next_wrap;

    assign terminal = up_dn ? limit : '0;

    // A count above a lowered limit is treated as "at or past the top" when counting up.
    always_comb begin
        next_count = count;
        next_term  = term_hit;
        next_wrap  = 1'b0;
        if (preload) begin
            next_count = (preload_val > limit) ? limit : preload_val;
            next_term  = (next_count == terminal);
        end else if (enable) begin
            if (up_dn) begin
                if (count < limit) begin
                    next_count = count + 1'b1;
                end else if (wrap_en) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = limit;
                end
            end else begin
                if (count != '0) begin
                    next_count = count - 1'b1;
                end else if (wrap_en) begin
                    next_count = limit;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = '0;
                end
            end
            next_term = (next_count == terminal);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count      <= RESET_VAL[WIDTH-1:0];
            term_hit   <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= next_count;
            term_hit   <= next_term;
            wrap_pulse <= next_wrap;
        end
    end

endmodule

// File: tb/tb_updown_limit_counter.sv
// Self-checking bench for updown_limit_counter: directed scenarios plus random
// traffic compared every cycle against a range-based behavioural model.
module tb_updown_limit_counter;

    localparam int WIDTH     = 4;
    localparam int RESET_VAL = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             enable;
    logic             up_dn;
    logic             wrap_en;
    logic             preload;
    logic [WIDTH-1:0] preload_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             term_hit;
    logic             wrap_pulse;

    int checks   = 0;
    int failures = 0;

    int m_count;
    bit m_term;
    bit m_wrap;
    bit m_valid = 1'b0;
    int m_lim;
    int m_next;

    updown_limit_counter #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .up_dn(up_dn),
        .wrap_en(wrap_en),
        .preload(preload),
        .preload_val(preload_val),
        .limit(limit),
        .count(count),
        .term_hit(term_hit),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    // Model: the legal range is 0..limit; a step that leaves it either wraps to the far end or clamps.
    always @(posedge clk) begin
        m_lim = int'(limit);
        if (!rstn) begin
            m_count = RESET_VAL;
            m_term  = 1'b0;
            m_wrap  = 1'b0;
            m_valid = 1'b1;
        end else if (preload) begin
            m_count = (int'(preload_val) > m_lim) ? m_lim : int'(preload_val);
            m_wrap  = 1'b0;
            m_term  = (m_count == (up_dn ? m_lim : 0));
        end else if (enable) begin
            m_next = up_dn ? m_count + 1 : m_count - 1;
            m_wrap = 1'b0;
            if (up_dn && m_next > m_lim) begin
                m_wrap = wrap_en;
                m_next = wrap_en ? 0 : m_lim;
            end else if (!up_dn && m_next < 0) begin
                m_wrap = wrap_en;
                m_next = wrap_en ? m_lim : 0;
            end
            m_count = m_next;
            m_term  = (m_count == (up_dn ? m_lim : 0));
        end else begin
            m_wrap = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks += 3;
            if (int'(count) != m_count) begin
                failures++;
                $display("[TB] FAIL model_count t=%0t got=%0d expected=%0d", $time, count, m_count);
            end
            if (term_hit != m_term) begin
                failures++;
                $display("[TB] FAIL model_term t=%0t got=%0b expected=%0b", $time, term_hit, m_term);
            end
            if (wrap_pulse != m_wrap) begin
                failures++;
                $display("[TB] FAIL model_wrap t=%0t got=%0b expected=%0b", $time, wrap_pulse, m_wrap);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic en, input logic ud, input logic we,
                                 input logic pl, input logic [WIDTH-1:0] pv,
                                 input logic [WIDTH-1:0] lim);
        rstn        = r;
        enable      = en;
        up_dn       = ud;
        wrap_en     = we;
        preload     = pl;
        preload_val = pv;
        limit       = lim;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int exp_count, input logic exp_term,
                               input logic exp_wrap);
        checks += 3;
        if (int'(count) != exp_count) begin
            failures++;
            $display("[TB] FAIL %s count got=%0d expected=%0d", name, count, exp_count);
        end
        if (term_hit != exp_term) begin
            failures++;
            $display("[TB] FAIL %s term_hit got=%0b expected=%0b", name, term_hit, exp_term);
        end
        if (wrap_pulse != exp_wrap) begin
            failures++;
            $display("[TB] FAIL %s wrap_pulse got=%0b expected=%0b", name, wrap_pulse, exp_wrap);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rnd_lim;
        applyStimulus(0, 1, 1, 1, 0, 4'd0, 4'd15);
        applyStimulus(0, 1, 1, 1, 0, 4'd0, 4'd15);
        checkOutput("reset", 3, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 4'd0, 4'd15);
        applyStimulus(1, 1, 1, 1, 0, 4'd0, 4'd15);
        checkOutput("after_reset_up2", 5, 0, 0);

        applyStimulus(1, 0, 1, 1, 1, 4'd0, 4'd9);
        for (int i = 0; i < 9; i++) applyStimulus(1, 1, 1, 1, 0, 4'd0, 4'd9);
        checkOutput("up_to_limit", 9, 1, 0);
        applyStimulus(1, 1, 1, 1, 0, 4'd0, 4'd9);
        checkOutput("up_wrap", 0, 0, 1);
        applyStimulus(1, 0, 1, 1, 0, 4'd0, 4'd9);
        checkOutput("wrap_one_cycle", 0, 0, 0);

        applyStimulus(1, 0, 0, 0, 1, 4'd2, 4'd9);
        checkOutput("preload_2_down", 2, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd9);
        applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd9);
        checkOutput("down_to_zero", 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd9);
            checkOutput("down_saturate", 0, 1, 0);
        end

        applyStimulus(1, 1, 1, 1, 1, 4'd12, 4'd6);
        checkOutput("preload_clamp", 6, 1, 0);

        applyStimulus(1, 0, 1, 1, 1, 4'd14, 4'd15);
        applyStimulus(1, 1, 1, 1, 0, 4'd0, 4'd15);
        checkOutput("dir_up_15", 15, 1, 0);
        applyStimulus(1, 1, 0, 1, 0, 4'd0, 4'd15);
        checkOutput("dir_down_14", 14, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, 4'd0, 4'd15);
        checkOutput("dir_hold", 14, 0, 0);

        applyStimulus(1, 0, 1, 0, 1, 4'd12, 4'd15);
        applyStimulus(1, 1, 1, 0, 0, 4'd0, 4'd5);
        checkOutput("lowered_sat", 5, 1, 0);
        applyStimulus(1, 0, 1, 1, 1, 4'd12, 4'd15);
        applyStimulus(1, 1, 1, 1, 0, 4'd0, 4'd5);
        checkOutput("lowered_wrap", 0, 0, 1);

        applyStimulus(1, 0, 1, 1, 1, 4'd0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 1, 1, 0, 4'd0, 4'd0);
            checkOutput("limit0_up", 0, 1, 1);
        end
        applyStimulus(1, 1, 0, 1, 0, 4'd0, 4'd0);
        checkOutput("limit0_down", 0, 1, 1);

        applyStimulus(1, 0, 0, 0, 1, 4'd11, 4'd13);
        applyStimulus(0, 1, 1, 1, 1, 4'd7, 4'd13);
        checkOutput("mid_reset", 3, 0, 0);

        rnd_lim = 4'd10;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) rnd_lim = WIDTH'($urandom_range(0, 15));
            applyStimulus(($urandom_range(0, 49) != 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0),
                          WIDTH'($urandom_range(0, 15)),
                          rnd_lim);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
